// File: rtl/snake_if.sv
// Bundles the snake engine's control inputs and game/body outputs.
// master = controller/display side, slave = the game engine.
interface snake_if #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
);
  logic                   dir_valid;
  logic [1:0]             dir_in;
  logic                   pause;
  logic                   slow;
  logic                   start;
  logic [X_W-1:0]         food_x;
  logic [Y_W-1:0]         food_y;
  logic                   food_valid;
  logic [1:0]             game_state;
  logic [1:0]             cur_dir;
  logic [MAX_LEN*X_W-1:0] snake_x_flat;
  logic [MAX_LEN*Y_W-1:0] snake_y_flat;
  logic [LEN_W-1:0]       length;
  logic                   step;
  logic                   get_food;
  logic                   hit_boundary;
  logic                   hit_self;

  modport master (
    output dir_valid, dir_in, pause, slow, start, food_x, food_y, food_valid,
    input  game_state, cur_dir, snake_x_flat, snake_y_flat, length,
           step, get_food, hit_boundary, hit_self
  );

  modport slave (
    input  dir_valid, dir_in, pause, slow, start, food_x, food_y, food_valid,
    output game_state, cur_dir, snake_x_flat, snake_y_flat, length,
           step, get_food, hit_boundary, hit_self
  );
endinterface

// File: rtl/snake_core.sv
// Snake game engine: step timer, 2-deep direction queue, body shift, collision and game FSM.
// Optional macro WRAP_EN: the head wraps to the opposite edge instead of dying at a wall.
module snake_core #(
  parameter int          GRID_W   = 32,
  parameter int          GRID_H   = 24,
  parameter int          X_W      = 5,
  parameter int          Y_W      = 5,
  parameter int          MAX_LEN  = 64,
  parameter int          LEN_W    = 7,
  parameter int          INIT_LEN = 3,
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned SLOW_MUL = 2
) (
  input  logic  clk,
  input  logic  rst,
  snake_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_DIE  = 2'b01,
    ST_INIT = 2'b10
  } state_e;

  localparam logic [1:0]  D_UP     = 2'b00;
  localparam logic [1:0]  D_DOWN   = 2'b01;
  localparam logic [1:0]  D_RIGHT  = 2'b10;
  localparam logic [31:0] PER_FAST = 32'(TICK_DIV);
  localparam logic [31:0] PER_SLOW = 32'(TICK_DIV * SLOW_MUL);

  state_e           state_q, state_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       dq_q [2];
  logic [1:0]       dq_d [2];
  logic [1:0]       dq_cnt_q, dq_cnt_d;
  logic [31:0]      tick_q, tick_d;
  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [X_W-1:0]   seg_x_d [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_d [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic             step_q, step_d;
  logic             get_food_q, get_food_d;
  logic             hit_b_q, hit_b_d;
  logic             hit_s_q, hit_s_d;

  logic [X_W-1:0]   init_x [MAX_LEN];
  logic [Y_W-1:0]   init_y [MAX_LEN];

  logic [1:0]       step_dir, last_dir;
  logic [X_W:0]     nx_raw;
  logic [Y_W:0]     ny_raw;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic             wall, grow, self_hit;
  logic [LEN_W-1:0] hit_lim;
  logic [MAX_LEN-1:0] self_hit_vec;
  logic [31:0]      period;
  logic             fire, accept, start_game;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      assign init_x[gi] = (gi < INIT_LEN) ? X_W'(GRID_W / 2 - gi) : '0;
      assign init_y[gi] = (gi < INIT_LEN) ? Y_W'(GRID_H / 2) : '0;
      assign bus.snake_x_flat[gi*X_W +: X_W] = seg_x_q[gi];
      assign bus.snake_y_flat[gi*Y_W +: Y_W] = seg_y_q[gi];
      assign self_hit_vec[gi] = (seg_x_q[gi] == nx) && (seg_y_q[gi] == ny) &&
                                (LEN_W'(gi) < hit_lim);
    end
  endgenerate

  assign self_hit = |self_hit_vec;

  // Candidate next head, computed one bit wider so stepping off 0 shows up as a large value.
  always_comb begin
    step_dir = (dq_cnt_q != 2'd0) ? dq_q[0] : cur_dir_q;
    nx_raw   = {1'b0, seg_x_q[0]};
    ny_raw   = {1'b0, seg_y_q[0]};
    case (step_dir)
      D_UP:    ny_raw = ny_raw - 1'b1;
      D_DOWN:  ny_raw = ny_raw + 1'b1;
      D_RIGHT: nx_raw = nx_raw + 1'b1;
      default: nx_raw = nx_raw - 1'b1;
    endcase
`ifdef WRAP_EN
    wall = 1'b0;
    if (nx_raw == '1)
      nx_raw = (X_W+1)'(GRID_W - 1);
    else if (nx_raw == (X_W+1)'(GRID_W))
      nx_raw = '0;
    if (ny_raw == '1)
      ny_raw = (Y_W+1)'(GRID_H - 1);
    else if (ny_raw == (Y_W+1)'(GRID_H))
      ny_raw = '0;
`else
    wall = (nx_raw > (X_W+1)'(GRID_W - 1)) || (ny_raw > (Y_W+1)'(GRID_H - 1));
`endif
    nx      = nx_raw[X_W-1:0];
    ny      = ny_raw[Y_W-1:0];
    grow    = bus.food_valid && (nx == bus.food_x) && (ny == bus.food_y);
    // The tail vacates its cell this step unless the snake grows.
    hit_lim = grow ? len_q : len_q - 1'b1;
  end

  always_comb begin
    period   = bus.slow ? PER_SLOW : PER_FAST;
    fire     = (state_q == ST_RUN) && !bus.pause && (tick_q >= period - 32'd1);
    last_dir = (dq_cnt_q == 2'd2) ? dq_q[1] :
               (dq_cnt_q == 2'd1) ? dq_q[0] : cur_dir_q;
    accept   = bus.dir_valid && (state_q != ST_DIE) && (dq_cnt_q != 2'd2) &&
               (bus.dir_in != last_dir) && (bus.dir_in != (last_dir ^ 2'b01));
    // Pressing the current heading on the start screen launches the game without queuing.
    start_game = (state_q == ST_INIT) && bus.dir_valid && (bus.dir_in == cur_dir_q);
  end

  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    dq_d       = dq_q;
    dq_cnt_d   = dq_cnt_q;
    tick_d     = tick_q;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    len_d      = len_q;
    step_d     = 1'b0;
    get_food_d = 1'b0;
    hit_b_d    = hit_b_q;
    hit_s_d    = hit_s_q;

    case (state_q)
      ST_INIT: if (accept || start_game) state_d = ST_RUN;
      ST_RUN:  if (!bus.pause) tick_d = fire ? 32'd0 : tick_q + 32'd1;
      ST_DIE:  ;
      default: state_d = ST_INIT;
    endcase

    if (fire) begin
      step_d    = 1'b1;
      cur_dir_d = step_dir;
      if (wall || self_hit) begin
        state_d = ST_DIE;
        hit_b_d = wall;
        hit_s_d = self_hit && !wall;
      end else begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nx;
        seg_y_d[0] = ny;
        if (grow) begin
          get_food_d = 1'b1;
          if (len_q != LEN_W'(MAX_LEN)) len_d = len_q + 1'b1;
        end
      end
    end

    // Pop for the step first, then append any request accepted this cycle.
    if (fire && (dq_cnt_q != 2'd0)) begin
      dq_d[0]  = dq_q[1];
      dq_cnt_d = dq_cnt_q - 2'd1;
    end
    if (accept) begin
      if (dq_cnt_d == 2'd0) dq_d[0] = bus.dir_in;
      else                  dq_d[1] = bus.dir_in;
      dq_cnt_d = dq_cnt_d + 2'd1;
    end

    if ((state_q == ST_DIE) && bus.start) begin
      state_d   = ST_INIT;
      cur_dir_d = D_RIGHT;
      dq_cnt_d  = 2'd0;
      tick_d    = 32'd0;
      seg_x_d   = init_x;
      seg_y_d   = init_y;
      len_d     = LEN_W'(INIT_LEN);
      hit_b_d   = 1'b0;
      hit_s_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cur_dir_q  <= D_RIGHT;
      dq_q       <= '{default: 2'b00};
      dq_cnt_q   <= 2'd0;
      tick_q     <= 32'd0;
      seg_x_q    <= init_x;
      seg_y_q    <= init_y;
      len_q      <= LEN_W'(INIT_LEN);
      step_q     <= 1'b0;
      get_food_q <= 1'b0;
      hit_b_q    <= 1'b0;
      hit_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      dq_q       <= dq_d;
      dq_cnt_q   <= dq_cnt_d;
      tick_q     <= tick_d;
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      len_q      <= len_d;
      step_q     <= step_d;
      get_food_q <= get_food_d;
      hit_b_q    <= hit_b_d;
      hit_s_q    <= hit_s_d;
    end
  end

  assign bus.game_state   = state_q;
  assign bus.cur_dir      = cur_dir_q;
  assign bus.length       = len_q;
  assign bus.step         = step_q;
  assign bus.get_food     = get_food_q;
  assign bus.hit_boundary = hit_b_q;
  assign bus.hit_self     = hit_s_q;

endmodule
